// File: rtl/m_rr_arbiter4.sv
// rtl/m_rr_arbiter4.sv - four-requester arbiter feeding one registered 32-bit word under valid/ready
// Round-robin or fixed-priority choice, one grant per transaction, IDLE/BUSY handshake.
module m_rr_arbiter4 #(
    parameter int WIDTH      = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    output logic [1:0]       select,
    output logic [3:0]       gnt,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [1:0]       start;
    logic [1:0]       idx;
    logic [1:0]       pick;
    logic             found;
    logic [WIDTH-1:0] pick_data;

    // Scan from the pointer (or from 0 in fixed priority) for the first active request.
    always_comb begin
        start = FIXED_PRIO ? 2'd0 : ptr_q;
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd0:    pick_data = a0;
            2'd1:    pick_data = a1;
            2'd2:    pick_data = a2;
            default: pick_data = a3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    data_d  = pick_data;
                    valid_d = 1'b1;
                    state_d = S_BUSY;
                end
            end
            default: begin
                // select and out_data deliberately hold after the handshake completes.
                if (out_ready) begin
                    valid_d = 1'b0;
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign select    = sel_q;
    assign gnt       = gnt_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ack       = {4{valid_q & out_ready}} & gnt_q;

endmodule

// File: tb/tb_m_rr_arbiter4.sv
// tb/tb_m_rr_arbiter4.sv - directed vector bench for m_rr_arbiter4
module tb_m_rr_arbiter4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] a0, a1, a2, a3;
    logic        out_ready;

    logic [1:0]  rr_select, fp_select;
    logic [3:0]  rr_gnt, fp_gnt, rr_ack, fp_ack;
    logic [31:0] rr_data, fp_data;
    logic        rr_valid, fp_valid;

    int n_checks = 0;
    int n_fail   = 0;

    m_rr_arbiter4 #(.WIDTH(32), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .select(rr_select), .gnt(rr_gnt), .ack(rr_ack),
        .out_data(rr_data), .out_valid(rr_valid), .out_ready(out_ready)
    );

    m_rr_arbiter4 #(.WIDTH(32), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .select(fp_select), .gnt(fp_gnt), .ack(fp_ack),
        .out_data(fp_data), .out_valid(fp_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a0, a1, a2, a3;
        logic        rdy;
        logic        vld;
        logic [1:0]  sel;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic [3:0] r, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic [31:0] d3, logic rdy,
                                logic vld, logic [1:0] sel, logic [3:0] g,
                                logic [3:0] k, logic [31:0] data);
        vec_t v;
        v.req = r; v.a0 = d0; v.a1 = d1; v.a2 = d2; v.a3 = d3; v.rdy = rdy;
        v.vld = vld; v.sel = sel; v.gnt = g; v.ack = k; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single requester, then reset-state check in the first vector
        vecs[0]  = mk(4'b0100, 0, 0, 32'hFFFF0000, 0, 1, 0, 2'd0, 4'b0000, 4'b0000, 32'h0);
        vecs[1]  = mk(4'b0100, 0, 0, 32'hFFFF0000, 0, 1, 1, 2'd2, 4'b0100, 4'b0100, 32'hFFFF0000);
        vecs[2]  = mk(4'b0000, 0, 0, 32'hFFFF0000, 0, 1, 0, 2'd2, 4'b0000, 4'b0000, 32'hFFFF0000);
        // ptr is now 3: all-request picks 3 first, then 0,1,2,3,0
        vecs[3]  = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd2, 4'b0000, 4'b0000, 32'hFFFF0000);
        vecs[4]  = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd3, 4'b1000, 4'b1000, 32'd3);
        vecs[5]  = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd3, 4'b0000, 4'b0000, 32'd3);
        vecs[6]  = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd0, 4'b0001, 4'b0001, 32'd0);
        vecs[7]  = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd0, 4'b0000, 4'b0000, 32'd0);
        vecs[8]  = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd1, 4'b0010, 4'b0010, 32'd1);
        vecs[9]  = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd1, 4'b0000, 4'b0000, 32'd1);
        vecs[10] = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd2, 4'b0100, 4'b0100, 32'd2);
        vecs[11] = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd2, 4'b0000, 4'b0000, 32'd2);
        vecs[12] = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd3, 4'b1000, 4'b1000, 32'd3);
        vecs[13] = mk(4'b1111, 0, 1, 2, 3, 1, 0, 2'd3, 4'b0000, 4'b0000, 32'd3);
        vecs[14] = mk(4'b1111, 0, 1, 2, 3, 1, 1, 2'd0, 4'b0001, 4'b0001, 32'd0);
        // backpressure: latched word must survive a1 toggling for 5 stalled cycles
        vecs[15] = mk(4'b0010, 0, 32'hAAAAAAAA, 2, 3, 0, 0, 2'd0, 4'b0000, 4'b0000, 32'd0);
        vecs[16] = mk(4'b0010, 0, 32'h55555555, 2, 3, 0, 1, 2'd1, 4'b0010, 4'b0000, 32'hAAAAAAAA);
        vecs[17] = mk(4'b0010, 0, 32'hAAAAAAAA, 2, 3, 0, 1, 2'd1, 4'b0010, 4'b0000, 32'hAAAAAAAA);
        vecs[18] = mk(4'b0010, 0, 32'h55555555, 2, 3, 0, 1, 2'd1, 4'b0010, 4'b0000, 32'hAAAAAAAA);
        vecs[19] = mk(4'b0010, 0, 32'hAAAAAAAA, 2, 3, 0, 1, 2'd1, 4'b0010, 4'b0000, 32'hAAAAAAAA);
        vecs[20] = mk(4'b0010, 0, 32'h55555555, 2, 3, 0, 1, 2'd1, 4'b0010, 4'b0000, 32'hAAAAAAAA);
        vecs[21] = mk(4'b0010, 0, 32'h55555555, 2, 3, 1, 1, 2'd1, 4'b0010, 4'b0010, 32'hAAAAAAAA);
        vecs[22] = mk(4'b0000, 0, 32'h55555555, 2, 3, 1, 0, 2'd1, 4'b0000, 4'b0000, 32'hAAAAAAAA);

        reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
        a0 = 0; a1 = 0; a2 = 0; a3 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            req = vecs[i].req; a0 = vecs[i].a0; a1 = vecs[i].a1;
            a2 = vecs[i].a2; a3 = vecs[i].a3; out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d valid", i),  32'(rr_valid),  32'(vecs[i].vld));
            chk($sformatf("v%0d select", i), 32'(rr_select), 32'(vecs[i].sel));
            chk($sformatf("v%0d gnt", i),    32'(rr_gnt),    32'(vecs[i].gnt));
            chk($sformatf("v%0d ack", i),    32'(rr_ack),    32'(vecs[i].ack));
            chk($sformatf("v%0d data", i),   rr_data,        vecs[i].data);
            tick();
        end

        // idle hold; out_ready toggling while invalid must be ignored
        for (int i = 0; i < 10; i++) begin
            req = 4'b0000;
            out_ready = i[0];
            #1;
            chk($sformatf("idle%0d valid", i),  32'(rr_valid),  32'd0);
            chk($sformatf("idle%0d gnt", i),    32'(rr_gnt),    32'd0);
            chk($sformatf("idle%0d ack", i),    32'(rr_ack),    32'd0);
            chk($sformatf("idle%0d select", i), 32'(rr_select), 32'd1);
            tick();
        end

        // reset mid-transaction; ptr is 2 here so only reset explains a grant to 0 afterwards
        req = 4'b1000; out_ready = 1'b0; a0 = 32'h12345678; a3 = 32'hCAFE0003;
        tick();
        chk("mid gnt", 32'(rr_gnt), 32'b1000);
        chk("mid select", 32'(rr_select), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("mid ack", 32'(rr_ack), 32'b1000);
        #2 reset = 1'b1;
        #1;
        chk("rst valid", 32'(rr_valid), 32'd0);
        chk("rst gnt", 32'(rr_gnt), 32'd0);
        chk("rst ack", 32'(rr_ack), 32'd0);
        chk("rst data", rr_data, 32'd0);
        req = 4'b1111;
        tick();
        reset = 1'b0;
        #1;
        chk("post-rst idle", 32'(rr_valid), 32'd0);
        tick();
        chk("post-rst gnt", 32'(rr_gnt), 32'b0001);
        chk("post-rst data", rr_data, 32'h12345678);

        // fixed priority: index 1 wins every time until it drops
        reset = 1'b1; req = 4'b1010; out_ready = 1'b1;
        a1 = 32'h11; a3 = 32'h33;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fp%0d gnt", i),    32'(fp_gnt),    32'b0010);
            chk($sformatf("fp%0d ack", i),    32'(fp_ack),    32'b0010);
            chk($sformatf("fp%0d select", i), 32'(fp_select), 32'd1);
            chk($sformatf("fp%0d data", i),   fp_data,        32'h11);
            tick();
            chk($sformatf("fp%0d idle", i),   32'(fp_valid),  32'd0);
            if (i == 2) req = 4'b1000;
        end
        tick();
        chk("fp last gnt", 32'(fp_gnt), 32'b1000);
        chk("fp last data", fp_data, 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_rr_arbiter4.md
Name: m_rr_arbiter4

Overview:
- Shares a single 32-bit downstream consumer between four requesters.
- Selects one requester per transaction (round-robin or fixed priority) and drives the select of the existing 4:1 32-bit multiplexor.
- Registers the selected word and holds it under a valid/ready handshake until the consumer accepts it.
- Sits between requester ports and the shared datapath sink, e.g. a memory write port or result bus.

Parameters:
- WIDTH, 32, data width of every requester word and of out_data.
- FIXED_PRIO, 0: 0 = round-robin; 1 = fixed priority (index 0 highest, 3 lowest).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  req[i] = requester i holds a valid word on a_i.
- a0  input  WIDTH  requester 0 data.
- a1  input  WIDTH  requester 1 data.
- a2  input  WIDTH  requester 2 data.
- a3  input  WIDTH  requester 3 data.
- select  output  2  registered index of the current grant; drives the 4:1 multiplexor select.
- gnt  output  4  registered one-hot grant; 0 when idle.
- ack  output  4  combinational one-hot: ack[i] = out_valid & out_ready & gnt[i].
- out_data  output  WIDTH  registered copy of the granted word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-transaction):
  - state = IDLE; out_valid = 0; gnt = 0; select = 0; out_data = 0; ptr = 0.
  - ack = 0 follows from gnt = 0.
  - An in-flight word is dropped; no ack is issued for it.
- States: IDLE and BUSY.
- IDLE:
  - If req == 0: remain in IDLE; all outputs hold.
  - Else, at the next edge: choose index k; select <= k; gnt <= 1<<k; out_data <= a_k (value sampled at that edge); out_valid <= 1; go to BUSY.
  - Latency: req rising to out_valid is 1 cycle.
- Choice of k:
  - Round-robin: first i with req[i] = 1, scanning ptr, ptr+1, ... modulo 4 (wraps 3 -> 0).
  - Fixed priority: lowest i with req[i] = 1; ptr is ignored.
- BUSY:
  - out_data, select and gnt are stable; later changes on a_k or req are ignored.
  - If out_ready = 0: stay in BUSY. There is no timeout.
  - If out_ready = 1: ack[k] pulses in that cycle. At the next edge: out_valid <= 0; gnt <= 0; ptr <= (k+1) mod 4; go to IDLE. select holds its last value.
- Requester protocol:
  - Hold req[i] and a_i until ack[i] is seen.
  - Drop req[i] at the edge after ack unless it has another word.
  - If req[i] is still 1 in the following IDLE cycle, it is treated as a new request.
- Throughput: maximum one transfer per 2 cycles (BUSY then IDLE).
- Simultaneous requests:
  - Exactly one grant per transaction; the others wait.
  - Round-robin guarantees each active requester is granted within 4 transactions.
- A requester dropping req while not granted has no effect.
- A requester dropping req while granted is a protocol violation: the transfer still completes with the latched data.
- out_ready while out_valid = 0 is ignored.

Test Plan:
- Reset then single requester: req=0100, a2=0xFFFF0000, out_ready=1.
  -> 1 cycle later: out_valid=1, select=2, gnt=0100, out_data=0xFFFF0000, ack=0100 in the same cycle.
  -> Next cycle: out_valid=0 and ptr=3.
- Round-robin fairness: req=1111 held (re-asserted after each ack), out_ready=1, a_i = i.
  -> Grant order 0,1,2,3,0 (wrap) on consecutive transactions.
  -> out_data matches index; transfers every 2 cycles.
- Backpressure: req=0010, a1=0xAAAAAAAA, out_ready=0 for 5 cycles while a1 toggles to 0x55555555.
  -> out_data stays 0xAAAAAAAA, ack=0.
  -> Raise out_ready: ack=0010 for exactly one cycle.
- Fixed priority (FIXED_PRIO=1): req=1010 continuously.
  -> Every grant goes to 1; requester 3 is granted only after req[1] drops.
- Reset mid-operation: BUSY with out_valid=1, gnt=1000; assert reset asynchronously between edges.
  -> out_valid, gnt and ack go to 0 immediately.
  -> After release with req=1111: first grant goes to index 0.
- Idle hold: req=0000 for 10 cycles after a transfer.
  -> out_valid=0, gnt=0, ack=0; select keeps its last value.
